// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one single-port memory between instruction fetch and data access
module rv32i_mem_arbiter #(
  parameter int unsigned FAIR_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        if_req_i,
  input  logic [31:0] if_add_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_add_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_ble_i,
  output logic [31:0] d_rdata_o,
  output logic        d_valid_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_add_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_ble_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        stall_o,
  output logic        err_o
);
  typedef enum logic [1:0] {IDLE, DATA, FETCH, RESP} state_t;
  state_t state, state_nx;
  logic [31:0] fair_cnt, to_cnt;
  logic grant_d, grant_f, wait_st, ack, tout, done;
  assign stall_o = (d_req_i & ~d_valid_o) | (if_req_i & ~if_valid_o);
  // grant decision, wait-state completion and next state
  always_comb begin
    grant_d = state == IDLE && d_req_i && (!if_req_i || fair_cnt < FAIR_MAX);
    grant_f = state == IDLE && if_req_i && !grant_d;
    wait_st = state == DATA || state == FETCH;
    ack = wait_st && mem_ack_i;
    tout = wait_st && !mem_ack_i && TIMEOUT_CYCLES != 0 && to_cnt == TIMEOUT_CYCLES - 1;
    done = ack || tout;
    state_nx = grant_d ? DATA : grant_f ? FETCH : done ? RESP : state == RESP ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk_i) state <= reset_i ? IDLE : state_nx;
  // memory request registers, fairness/timeout counters and responses
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_add_o <= '0;
      mem_wdata_o <= '0;
      mem_ble_o <= '0;
      if_valid_o <= 1'b0;
      d_valid_o <= 1'b0;
      if_rdata_o <= '0;
      d_rdata_o <= '0;
      err_o <= 1'b0;
      fair_cnt <= '0;
      to_cnt <= '0;
    end else begin
      mem_req_o <= state_nx == DATA || state_nx == FETCH;
      if (grant_d) begin
        mem_we_o <= d_we_i;
        mem_add_o <= d_add_i;
        mem_wdata_o <= d_wdata_i;
        mem_ble_o <= d_ble_i;
      end else if (grant_f) begin
        mem_we_o <= 1'b0;
        mem_add_o <= if_add_i;
        mem_wdata_o <= '0;
        mem_ble_o <= 4'hF;
      end
      if (grant_f || (grant_d && !if_req_i)) fair_cnt <= '0;
      else if (grant_d && fair_cnt < FAIR_MAX) fair_cnt <= fair_cnt + 32'd1;
      to_cnt <= (wait_st && !done) ? to_cnt + 32'd1 : '0;
      if_valid_o <= done && state == FETCH;
      d_valid_o <= done && state == DATA;
      if (done && state == FETCH) if_rdata_o <= ack ? mem_rdata_i : '0;
      if (done && state == DATA && !mem_we_o) d_rdata_o <= ack ? mem_rdata_i : '0;
      if (tout) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: scoreboard bench for the fetch/data memory arbiter
module tb_rv32i_mem_arbiter;
  logic clk_i = 0, reset_i = 1;
  logic if_req_i = 0, d_req_i = 0, d_we_i = 0;
  logic [31:0] if_add_i = 0, d_add_i = 0, d_wdata_i = 0;
  logic [3:0] d_ble_i = 0;
  logic [31:0] if_rdata_o, d_rdata_o, mem_add_o, mem_wdata_o, mem_rdata_i;
  logic if_valid_o, d_valid_o, mem_req_o, mem_we_o, mem_ack_i, stall_o, err_o;
  logic [3:0] mem_ble_o;
  typedef struct packed {logic we; logic [31:0] add; logic [31:0] wdata; logic [3:0] ble;} gnt_t;
  gnt_t exp_g[$];
  logic [31:0] exp_if[$], exp_d[$];
  int checks = 0, errors = 0;
  int ack_dly = 1, last_len = 0;
  bit no_ack = 0;
  rv32i_mem_arbiter #(.FAIR_MAX(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .if_req_i(if_req_i), .if_add_i(if_add_i), .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_add_i(d_add_i), .d_wdata_i(d_wdata_i), .d_ble_i(d_ble_i),
    .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_add_o(mem_add_o), .mem_wdata_o(mem_wdata_o),
    .mem_ble_o(mem_ble_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a == 32'h100 ? 32'h00500093 : {a[15:0], ~a[15:0]};
  endfunction
  // memory model: acks after ack_dly wait cycles, junk data otherwise
  initial begin
    int acnt = 0;
    mem_ack_i = 0;
    mem_rdata_i = 0;
    forever begin
      @(negedge clk_i);
      acnt = mem_req_o ? acnt + 1 : 0;
      mem_ack_i = mem_req_o && !no_ack && acnt == ack_dly;
      mem_rdata_i = mem_ack_i ? mem_val(mem_add_o) : 32'hBAD0BAD0;
    end
  end
  // monitor: grants, hold stability and completions against the scoreboard
  initial begin
    gnt_t g, held;
    bit prev_req = 0, stable = 1;
    int len = 0;
    forever begin
      @(negedge clk_i);
      if (!reset_i) begin
        if (mem_req_o && !prev_req) begin
          if (exp_g.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_unexpected: got add %h expected none", mem_add_o);
          end else begin
            g = exp_g.pop_front();
            check("grant_we", {31'd0, mem_we_o}, {31'd0, g.we});
            check("grant_add", mem_add_o, g.add);
            check("grant_ble", {28'd0, mem_ble_o}, {28'd0, g.ble});
            if (g.we) check("grant_wdata", mem_wdata_o, g.wdata);
          end
          held = {mem_we_o, mem_add_o, mem_wdata_o, mem_ble_o};
          stable = 1;
          len = 0;
        end
        if (mem_req_o) begin
          len++;
          if ({mem_we_o, mem_add_o, mem_wdata_o, mem_ble_o} != held) stable = 0;
        end
        if (!mem_req_o && prev_req) begin
          check("hold_stable", {31'd0, stable}, 32'd1);
          last_len = len;
        end
        if (if_valid_o) begin
          if (exp_if.size() == 0) begin
            checks++; errors++;
            $display("FAIL if_valid_unexpected: got rdata %h expected no pulse", if_rdata_o);
          end else check("if_rdata", if_rdata_o, exp_if.pop_front());
        end
        if (d_valid_o) begin
          if (exp_d.size() == 0) begin
            checks++; errors++;
            $display("FAIL d_valid_unexpected: got rdata %h expected no pulse", d_rdata_o);
          end else check("d_rdata", d_rdata_o, exp_d.pop_front());
        end
      end
      prev_req = mem_req_o;
    end
  end
  task automatic wait_v(input bit f);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(f ? if_valid_o : d_valid_o) && n < 200);
    if (n >= 200) check(f ? "if_valid_wait" : "d_valid_wait", 32'd0, 32'd1);
  endtask
  task automatic fetch(input logic [31:0] a);
    if_req_i = 1;
    if_add_i = a;
    wait_v(1);
    if_req_i = 0;
  endtask
  task automatic data(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ble);
    d_req_i = 1;
    d_we_i = we;
    d_add_i = a;
    d_wdata_i = wd;
    d_ble_i = ble;
    wait_v(0);
    d_req_i = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk_i);
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_mem_add", mem_add_o, 32'd0);
    check("rst_mem_ble", {28'd0, mem_ble_o}, 32'd0);
    check("rst_valids", {30'd0, if_valid_o, d_valid_o}, 32'd0);
    check("rst_if_rdata", if_rdata_o, 32'd0);
    check("rst_d_rdata", d_rdata_o, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    reset_i = 0;
    exp_g.push_back({1'b0, 32'h100, 32'h0, 4'hF});
    exp_if.push_back(32'h00500093);
    fetch(32'h100);
    @(negedge clk_i);
    check("fetch_stall_after", {31'd0, stall_o}, 32'd0);
    exp_g.push_back({1'b0, 32'h2000, 32'h0, 4'hF});
    exp_g.push_back({1'b0, 32'h104, 32'h0, 4'hF});
    exp_d.push_back(32'h2000DFFF);
    exp_if.push_back(32'h0104FEFB);
    fork
      fetch(32'h104);
      data(0, 32'h2000, 0, 4'hF);
      repeat (4) begin
        @(negedge clk_i);
        check("collision_stall", {31'd0, stall_o}, 32'd1);
      end
    join
    foreach (exp_d[i]) ;
    for (int i = 0; i < 4; i++) exp_g.push_back({1'b0, 32'h3000 + 32'(4 * i), 32'h0, 4'hF});
    exp_g.push_back({1'b0, 32'h108, 32'h0, 4'hF});
    exp_g.push_back({1'b0, 32'h3010, 32'h0, 4'hF});
    exp_g.push_back({1'b0, 32'h3014, 32'h0, 4'hF});
    exp_if.push_back(32'h0108FEF7);
    exp_d.push_back(32'h3000CFFF);
    exp_d.push_back(32'h3004CFFB);
    exp_d.push_back(32'h3008CFF7);
    exp_d.push_back(32'h300CCFF3);
    exp_d.push_back(32'h3010CFEF);
    exp_d.push_back(32'h3014CFEB);
    fork
      fetch(32'h108);
      for (int i = 0; i < 6; i++) data(0, 32'h3000 + 32'(4 * i), 0, 4'hF);
    join
    ack_dly = 3;
    exp_g.push_back({1'b1, 32'h40, 32'hDEADBEEF, 4'b0011});
    exp_d.push_back(32'h3014CFEB);
    data(1, 32'h40, 32'hDEADBEEF, 4'b0011);
    ack_dly = 1;
    no_ack = 1;
    exp_g.push_back({1'b0, 32'h300, 32'h0, 4'hF});
    exp_d.push_back(32'h0);
    data(0, 32'h300, 0, 4'hF);
    @(negedge clk_i);
    check("timeout_err", {31'd0, err_o}, 32'd1);
    check("timeout_req_drop", {31'd0, mem_req_o}, 32'd0);
    check("timeout_wait_len", last_len, 32'd8);
    no_ack = 0;
    exp_g.push_back({1'b0, 32'h10C, 32'h0, 4'hF});
    exp_if.push_back(32'h010CFEF3);
    fetch(32'h10C);
    check("err_sticky", {31'd0, err_o}, 32'd1);
    no_ack = 1;
    exp_g.push_back({1'b0, 32'h500, 32'h0, 4'hF});
    d_req_i = 1;
    d_we_i = 0;
    d_add_i = 32'h500;
    d_ble_i = 4'hF;
    repeat (3) @(negedge clk_i);
    check("pre_reset_req", {31'd0, mem_req_o}, 32'd1);
    reset_i = 1;
    @(negedge clk_i);
    check("midrst_req", {31'd0, mem_req_o}, 32'd0);
    check("midrst_err", {31'd0, err_o}, 32'd0);
    check("midrst_valid", {31'd0, d_valid_o}, 32'd0);
    reset_i = 0;
    d_req_i = 0;
    no_ack = 0;
    repeat (3) begin
      @(negedge clk_i);
      check("midrst_no_pulse", {31'd0, d_valid_o}, 32'd0);
    end
    exp_g.push_back({1'b0, 32'h110, 32'h0, 4'hF});
    exp_if.push_back(32'h0110FEEF);
    fetch(32'h110);
    repeat (2) @(negedge clk_i);
    check("left_grants", exp_g.size(), 32'd0);
    check("left_if", exp_if.size(), 32'd0);
    check("left_d", exp_d.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
- Arbitrates a single shared, single-port memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Sits between the RV32i core's imem/dmem interfaces and the unified memory.
- Serialises requests and holds one transaction outstanding at a time.
- Generates the pipeline stall while a requester waits, and flags a memory timeout.

Parameters:
- FAIR_MAX, 4: maximum consecutive data grants while a fetch is pending before one fetch grant is forced (≥1).
- TIMEOUT_CYCLES, 64: cycles in a wait state without mem_ack_i before the transaction is abandoned; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset
- if_req_i  in  1  fetch request, held high until if_valid_o
- if_add_i  in  32  fetch address
- if_rdata_o  out  32  fetched instruction
- if_valid_o  out  1  one-cycle fetch completion pulse
- d_req_i  in  1  data request, held high until d_valid_o
- d_we_i  in  1  1=store, 0=load
- d_add_i  in  32  data address
- d_wdata_i  in  32  store data
- d_ble_i  in  4  byte lane enables
- d_rdata_o  out  32  load data
- d_valid_o  out  1  one-cycle data completion pulse
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_add_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_ble_o  out  4  memory byte lanes
- mem_rdata_i  in  32  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion
- stall_o  out  1  pipeline stall
- err_o  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values: state=IDLE, mem_req_o=0, mem_we_o=0, mem_add_o=0, mem_wdata_o=0, mem_ble_o=0, if_valid_o=0, d_valid_o=0, if_rdata_o=0, d_rdata_o=0, err_o=0, fair counter=0, timeout counter=0.
- FSM states: IDLE, DATA, FETCH, RESP.
- IDLE, grant:
  - If d_req_i=1 and (if_req_i=0 or fair counter<FAIR_MAX), grant data.
  - Else if if_req_i=1, grant fetch.
  - On grant, register the selected address/data/ble/we into the mem_* outputs and go to DATA or FETCH. mem_req_o rises at the next edge.
  - A fetch grant drives mem_we_o=0 and mem_ble_o=4'b1111.
- Fair counter:
  - Increments on each data grant made while if_req_i=1.
  - Clears on any fetch grant, and on a data grant made while if_req_i=0.
  - Saturates at FAIR_MAX.
- DATA/FETCH:
  - mem_req_o=1 and all mem_* outputs are held stable.
  - On the cycle mem_ack_i=1, capture mem_rdata_i, drop mem_req_o at the next edge and go to RESP.
  - Captured data goes to if_rdata_o (fetch) or d_rdata_o (load only). d_rdata_o is unchanged after a store.
- RESP:
  - Exactly one cycle. Pulses the matching valid (if_valid_o or d_valid_o), then goes to IDLE.
  - Requests are not sampled in RESP.
- Latency: grant edge → mem_req_o 1 cycle; mem_ack_i cycle → valid pulse 1 cycle later. Minimum request-to-valid is 3 cycles with ack in the first wait cycle.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter clears on entry to DATA/FETCH and increments each wait cycle.
  - If it reaches TIMEOUT_CYCLES with no ack: set err_o, drop mem_req_o, go to RESP, and return rdata=0 with a valid pulse.
  - err_o clears only on reset.
- stall_o is combinational: (d_req_i & ~d_valid_o) | (if_req_i & ~if_valid_o).
- Simultaneous mem_ack_i and timeout in the same cycle: the ack wins and err_o is not set.
- mem_ack_i while in IDLE or RESP is ignored.
- Reset mid-transaction: IDLE at the next edge, mem_req_o=0, the pending transaction is dropped with no valid pulse, and err_o is cleared.

Test Plan:
- Single fetch: if_req_i=1, if_add_i=0x100, memory acks 1 cycle after mem_req_o with 0x00500093 → mem_add_o=0x100, mem_ble_o=4'hF, if_rdata_o=0x00500093, if_valid_o pulses exactly once, stall_o=0 the cycle after.
- Collision: if_req_i and d_req_i (load 0x2000) asserted together → data granted first (mem_add_o=0x2000), then fetch; d_valid_o precedes if_valid_o; stall_o=1 throughout.
- Fairness, FAIR_MAX=4: d_req_i continuously re-asserted and if_req_i held → exactly 4 data grants, then 1 fetch grant, then data resumes.
- Store: d_we_i=1, d_add_i=0x40, d_wdata_i=0xDEADBEEF, d_ble_i=4'b0011 → mem_we_o=1 with those values held until ack; d_rdata_o keeps its prior value; d_valid_o pulses.
- Timeout, TIMEOUT_CYCLES=8, no ack → after 8 wait cycles mem_req_o=0, err_o=1 (sticky), d_valid_o pulses with d_rdata_o=0.
- reset_i=1 during the DATA wait → next edge mem_req_o=0, no valid pulse, err_o=0, state IDLE.
